tri_dispatch: RTL and testbench

Triangle queue and dispatcher sitting directly upstream of `rasterizer`. Accepts screen-space triangles from the transform stage over a valid/ready port, buffers them in a small FIFO, rejects degenerate, fully off-screen and (optionally) back-facing triangles, and issues survivors to the rasterizer using its `i_tri_valid` / `o_busy` handshake. It also reports per-frame drawn and culled counts.

---
 rtl/raster_pkg.sv | 29 ++
 rtl/tri_fifo.sv | 38 +++
 rtl/tri_dispatch.sv | 102 ++++++++++
 tb/tb_tri_dispatch.sv | 251 +++++++++++++++++++++++++
 4 files changed

// File: rtl/raster_pkg.sv
// raster_pkg: triangle/vertex types, screen defaults, area width and dispatcher states
package raster_pkg;

    typedef struct packed {
        logic signed [15:0] x;
        logic signed [15:0] y;
        logic [7:0]         z;
        logic [31:0]        u;
        logic [31:0]        v;
    } vertex_t;

    typedef struct packed {
        vertex_t v0;
        vertex_t v1;
        vertex_t v2;
    } tri_t;

    localparam int SCR_W_DEF = 320;
    localparam int SCR_H_DEF = 240;
    localparam int AREA_W    = 35;

    typedef enum logic [2:0] {S_IDLE, S_LOAD, S_CHECK, S_ISSUE, S_RUN} disp_state_e;

    function automatic logic all_ge(logic signed [15:0] a, logic signed [15:0] b,
                                    logic signed [15:0] c, int lim);
        return int'(a) >= lim && int'(b) >= lim && int'(c) >= lim;
    endfunction

endpackage

// File: rtl/tri_fifo.sv
// tri_fifo: synchronous FIFO, extra pointer MSB distinguishes full from empty
module tri_fifo #(
    parameter int W     = 8,
    parameter int DEPTH = 4
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         push,
    input  logic         pop,
    input  logic [W-1:0] din,
    output logic [W-1:0] dout,
    output logic         full,
    output logic         empty
);
    localparam int AW = $clog2(DEPTH);

    logic [W-1:0] mem [DEPTH];
    logic [AW:0]  wr_ptr, rd_ptr;

    assign full  = (wr_ptr ^ rd_ptr) == {1'b1, {AW{1'b0}}};
    assign empty = wr_ptr == rd_ptr;
    assign dout  = mem[rd_ptr[AW-1:0]];

    // pointers only move on legal push/pop; a full FIFO refuses pushes even while popping
    always_ff @(posedge clk or posedge rst)
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (push && !full) wr_ptr <= wr_ptr + 1'b1;
            if (pop && !empty) rd_ptr <= rd_ptr + 1'b1;
        end

    // payload storage needs no reset; occupancy is tracked by the pointers
    always_ff @(posedge clk)
        if (push && !full) mem[wr_ptr[AW-1:0]] <= din;

endmodule

// File: rtl/tri_dispatch.sv
// tri_dispatch: triangle FIFO + cull/dispatch FSM to rasterizer; TRI_CULL_EN adds back-face culling
import raster_pkg::*;

module tri_dispatch #(
    parameter int DEPTH = 4,
    parameter int SCR_W = SCR_W_DEF,
    parameter int SCR_H = SCR_H_DEF
) (
    input  logic               i_clk,
    input  logic               i_rst,
    input  logic               i_s_valid,
    output logic               o_s_ready,
    input  tri_t               i_s_tri,
    output logic               o_tri_valid,
    input  logic               i_busy,
    output logic signed [15:0] o_x0, o_y0, o_x1, o_y1, o_x2, o_y2,
    output logic [7:0]         o_z0, o_z1, o_z2,
    output logic [31:0]        o_u0, o_v0, o_u1, o_v1, o_u2, o_v2,
    input  logic               i_cnt_clr,
    output logic [15:0]        o_drawn_cnt,
    output logic [15:0]        o_cull_cnt,
    output logic               o_idle
);
    disp_state_e              state, state_nx;
    tri_t                     cur, head;
    logic                     full, empty, push, pop, reject, back;
    logic signed [16:0]       dx1, dy1, dx2, dy2;
    logic signed [33:0]       p_a, p_b;
    logic signed [AREA_W-1:0] area;

    assign o_s_ready = !full && !i_rst;
    assign push      = i_s_valid && o_s_ready;
    assign pop       = state == S_LOAD;

    tri_fifo #(.W($bits(tri_t)), .DEPTH(DEPTH)) u_fifo (
        .clk(i_clk), .rst(i_rst), .push(push), .pop(pop),
        .din(i_s_tri), .dout(head), .full(full), .empty(empty)
    );

    assign dx1  = 17'(cur.v1.x) - 17'(cur.v0.x);
    assign dy1  = 17'(cur.v1.y) - 17'(cur.v0.y);
    assign dx2  = 17'(cur.v2.x) - 17'(cur.v0.x);
    assign dy2  = 17'(cur.v2.y) - 17'(cur.v0.y);
    assign p_a  = 34'(dx1) * 34'(dy2);
    assign p_b  = 34'(dx2) * 34'(dy1);
    assign area = AREA_W'(p_a) - AREA_W'(p_b);

`ifdef TRI_CULL_EN
    assign back = !area[AREA_W-1] && area != '0;
`else
    assign back = 1'b0;
`endif

    assign reject = area == '0 || back
                 || (cur.v0.x[15] && cur.v1.x[15] && cur.v2.x[15])
                 || (cur.v0.y[15] && cur.v1.y[15] && cur.v2.y[15])
                 || all_ge(cur.v0.x, cur.v1.x, cur.v2.x, SCR_W)
                 || all_ge(cur.v0.y, cur.v1.y, cur.v2.y, SCR_H);

    assign o_tri_valid = state == S_ISSUE;
    assign o_idle      = empty && state == S_IDLE && !i_busy;

    assign {o_x0, o_y0, o_z0, o_u0, o_v0} = cur.v0;
    assign {o_x1, o_y1, o_z1, o_u1, o_v1} = cur.v1;
    assign {o_x2, o_y2, o_z2, o_u2, o_v2} = cur.v2;

    // state register; reset drops o_tri_valid immediately since it decodes state
    always_ff @(posedge i_clk or posedge i_rst)
        if (i_rst) state <= S_IDLE;
        else       state <= state_nx;

    // next state: the cull decision is made in CHECK from the freshly loaded vertices
    always_comb begin
        state_nx = state;
        case (state)
            S_IDLE:  state_nx = (!empty && !i_busy) ? S_LOAD : S_IDLE;
            S_LOAD:  state_nx = S_CHECK;
            S_CHECK: state_nx = reject ? S_IDLE : S_ISSUE;
            S_ISSUE: state_nx = i_busy ? S_RUN : S_ISSUE;
            S_RUN:   state_nx = i_busy ? S_RUN : S_IDLE;
            default: state_nx = S_IDLE;
        endcase
    end

    // vertex output registers load on pop; counters with clear taking priority
    always_ff @(posedge i_clk or posedge i_rst)
        if (i_rst) begin
            cur         <= '0;
            o_drawn_cnt <= '0;
            o_cull_cnt  <= '0;
        end else begin
            if (pop) cur <= head;
            if (i_cnt_clr) begin
                o_drawn_cnt <= '0;
                o_cull_cnt  <= '0;
            end else begin
                if (state == S_CHECK && reject) o_cull_cnt  <= o_cull_cnt + 1'b1;
                if (state == S_ISSUE && i_busy) o_drawn_cnt <= o_drawn_cnt + 1'b1;
            end
        end

endmodule

// File: tb/tb_tri_dispatch.sv
// tb_tri_dispatch: directed + randomized checks of tri_dispatch against a spec-level model
module tb_tri_dispatch;
    import raster_pkg::*;

    logic clk = 1'b0, rst = 1'b1, s_valid = 1'b0, busy = 1'b0, cnt_clr = 1'b0;
    logic s_ready, tri_valid, idle;
    tri_t s_tri = '0;
    logic signed [15:0] x0, y0, x1, y1, x2, y2;
    logic [7:0]  z0, z1, z2;
    logic [31:0] u0, v0, u1, v1, u2, v2;
    logic [15:0] drawn, cull;
    int vecs = 0, errs = 0, exp_drawn = 0, exp_cull = 0;
    tri_t q[$];

    always #5 clk = ~clk;

    tri_dispatch dut (
        .i_clk(clk), .i_rst(rst), .i_s_valid(s_valid), .o_s_ready(s_ready), .i_s_tri(s_tri),
        .o_tri_valid(tri_valid), .i_busy(busy),
        .o_x0(x0), .o_y0(y0), .o_x1(x1), .o_y1(y1), .o_x2(x2), .o_y2(y2),
        .o_z0(z0), .o_z1(z1), .o_z2(z2),
        .o_u0(u0), .o_v0(v0), .o_u1(u1), .o_v1(v1), .o_u2(u2), .o_v2(v2),
        .i_cnt_clr(cnt_clr), .o_drawn_cnt(drawn), .o_cull_cnt(cull), .o_idle(idle)
    );

    function automatic tri_t got_tri();
        return {x0, y0, z0, u0, v0, x1, y1, z1, u1, v1, x2, y2, z2, u2, v2};
    endfunction

    task automatic chk(input string tag, input logic [311:0] got, input logic [311:0] exp);
        vecs++;
        assert (got === exp) else begin
            errs++;
            $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic tri_t mk(int ax0, int ay0, int ax1, int ay1, int ax2, int ay2);
        logic [319:0] r;
        tri_t t;
        for (int i = 0; i < 10; i++) r[i*32 +: 32] = $urandom;
        t = r[311:0];
        t.v0.x = 16'(ax0); t.v0.y = 16'(ay0);
        t.v1.x = 16'(ax1); t.v1.y = 16'(ay1);
        t.v2.x = 16'(ax2); t.v2.y = 16'(ay2);
        return t;
    endfunction

    // reference: plain signed arithmetic on the vertex coordinates
    function automatic bit drawn_ok(tri_t t);
        longint a;
        int xs[3], ys[3];
        bit off;
        xs[0] = int'(t.v0.x); xs[1] = int'(t.v1.x); xs[2] = int'(t.v2.x);
        ys[0] = int'(t.v0.y); ys[1] = int'(t.v1.y); ys[2] = int'(t.v2.y);
        a = longint'(xs[1] - xs[0]) * longint'(ys[2] - ys[0])
          - longint'(xs[2] - xs[0]) * longint'(ys[1] - ys[0]);
        off = (xs[0] < 0 && xs[1] < 0 && xs[2] < 0) || (ys[0] < 0 && ys[1] < 0 && ys[2] < 0)
           || (xs[0] >= 320 && xs[1] >= 320 && xs[2] >= 320)
           || (ys[0] >= 240 && ys[1] >= 240 && ys[2] >= 240);
`ifdef TRI_CULL_EN
        if (a > 0) return 1'b0;
`endif
        return a != 0 && !off;
    endfunction

    task automatic send(input tri_t t, input bit pre_busy);
        bit ok;
        ok = drawn_ok(t);
        @(negedge clk);
        chk("ready_before_push", s_ready, 1);
        s_valid = 1'b1;
        s_tri   = t;
        @(negedge clk);
        s_valid = 1'b0;
        @(negedge clk);
        chk("valid_in_load", tri_valid, 0);
        @(negedge clk);
        chk("valid_in_check", tri_valid, 0);
        chk("vertex_out", got_tri(), t);
        if (pre_busy) busy = 1'b1;
        @(negedge clk);
        chk("valid_after_check", tri_valid, ok);
        if (!ok) begin
            exp_cull++;
            chk("cull_cnt", cull, exp_cull);
            chk("idle_after_reject", idle, !pre_busy);
        end else begin
            int hold;
            hold = pre_busy ? 0 : $urandom_range(0, 3);
            repeat (hold) begin
                @(negedge clk);
                chk("valid_hold", tri_valid, 1);
            end
            busy = 1'b1;
            @(negedge clk);
            chk("valid_drop", tri_valid, 0);
            exp_drawn++;
            chk("drawn_cnt", drawn, exp_drawn);
            chk("vertex_hold", got_tri(), t);
            repeat ($urandom_range(0, 3)) @(negedge clk);
            busy = 1'b0;
            @(negedge clk);
            chk("idle_after_run", idle, 1);
        end
        busy = 1'b0;
    endtask

    initial begin
        tri_t t;
        repeat (2) @(negedge clk);
        chk("rst_ready", s_ready, 0);
        chk("rst_valid", tri_valid, 0);
        chk("rst_drawn", drawn, 0);
        chk("rst_cull", cull, 0);
        chk("rst_idle", idle, 1);
        chk("rst_vertices", got_tri(), 0);
        rst = 1'b0;
        @(negedge clk);
        chk("ready_after_reset", s_ready, 1);

        send(mk(160, 110, 150, 130, 170, 130), 1'b0);
        send(mk(0, 0, 10, 10, 20, 20), 1'b0);
        send(mk(330, 0, 340, 50, 350, 10), 1'b0);
        send(mk(10, -5, 50, -5, 30, -5), 1'b0);
        send(mk(160, 110, 170, 130, 150, 130), 1'b0);
        send(mk(160, 110, 150, 130, 170, 130), 1'b1);

        for (int i = 0; i < 30; i++) begin
            if (i % 5 == 4)
                send(mk($urandom_range(0, 65535) - 32768, $urandom_range(0, 65535) - 32768,
                        $urandom_range(0, 65535) - 32768, $urandom_range(0, 65535) - 32768,
                        $urandom_range(0, 65535) - 32768, $urandom_range(0, 65535) - 32768),
                     1'($urandom_range(0, 1)));
            else
                send(mk($urandom_range(0, 400) - 40, $urandom_range(0, 300) - 30,
                        $urandom_range(0, 400) - 40, $urandom_range(0, 300) - 30,
                        $urandom_range(0, 400) - 40, $urandom_range(0, 300) - 30),
                     1'($urandom_range(0, 1)));
        end

        // clear coinciding with a reject increment: clear wins
        @(negedge clk);
        s_valid = 1'b1;
        s_tri   = mk(0, 0, 10, 10, 20, 20);
        @(negedge clk);
        s_valid = 1'b0;
        repeat (2) @(negedge clk);
        cnt_clr = 1'b1;
        @(negedge clk);
        cnt_clr = 1'b0;
        exp_cull = 0;
        exp_drawn = 0;
        chk("clr_cull", cull, 0);
        chk("clr_drawn", drawn, 0);

        // fill the FIFO while the rasterizer is busy
        busy = 1'b1;
        for (int i = 0; i < 4; i++) begin
            t = mk(100 + i * 10, 110, 90 + i * 10, 130, 110 + i * 10, 130);
            q.push_back(t);
            @(negedge clk);
            chk("fill_ready", s_ready, 1);
            s_valid = 1'b1;
            s_tri   = t;
        end
        @(negedge clk);
        chk("ready_full", s_ready, 0);
        t = mk(200, 50, 190, 70, 210, 70);
        q.push_back(t);
        s_tri = t;
        repeat (3) begin
            @(negedge clk);
            chk("ready_full_hold", s_ready, 0);
        end
        fork
            begin
                int w = 0;
                while (!s_ready && w < 60) begin
                    @(negedge clk);
                    w++;
                end
                chk("fifth_accepted", s_ready, 1);
                @(negedge clk);
                s_valid = 1'b0;
            end
            begin
                busy = 1'b0;
                for (int k = 0; k < 5; k++) begin
                    int w = 0;
                    while (!tri_valid && w < 60) begin
                        @(negedge clk);
                        w++;
                    end
                    chk("issue_seen", tri_valid, 1);
                    chk("issue_order", got_tri(), q.pop_front());
                    busy = 1'b1;
                    @(negedge clk);
                    chk("issue_drop", tri_valid, 0);
                    busy = 1'b0;
                    @(negedge clk);
                end
            end
        join
        exp_drawn += 5;
        chk("drawn_after_drain", drawn, exp_drawn);
        chk("idle_after_drain", idle, 1);

        // reset while a triangle is being issued and another is queued
        @(negedge clk);
        s_valid = 1'b1;
        s_tri   = mk(160, 110, 150, 130, 170, 130);
        @(negedge clk);
        s_tri   = mk(60, 110, 50, 130, 70, 130);
        @(negedge clk);
        s_valid = 1'b0;
        begin
            int w = 0;
            while (!tri_valid && w < 20) begin
                @(negedge clk);
                w++;
            end
        end
        chk("issue_before_reset", tri_valid, 1);
        #2;
        busy = 1'b1;
        rst  = 1'b1;
        #1;
        chk("async_valid_drop", tri_valid, 0);
        chk("reset_ready", s_ready, 0);
        chk("reset_drawn", drawn, 0);
        chk("reset_cull", cull, 0);
        chk("reset_idle_busy", idle, 0);
        @(negedge clk);
        busy = 1'b0;
        #1;
        chk("reset_idle", idle, 1);
        rst = 1'b0;
        @(negedge clk);
        chk("ready_after_midreset", s_ready, 1);
        repeat (4) begin
            @(negedge clk);
            chk("no_issue_after_reset", tri_valid, 0);
            chk("idle_after_reset", idle, 1);
        end

        $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
        $finish;
    end

endmodule
